// File: rtl/chip_valve_sequencer.sv
// -----------------------------------------------------------------------------
// chip_valve_sequencer
//
// Purpose:
//   Control-layer sequencer for the parametrised ChIP chip. One accepted command
//   opens a reagent inlet plus the in/out valves of one ring and lets them settle.
//   It then runs the 3-phase peristaltic pump for a given number of strokes,
//   closes everything and lets it settle again, optionally flushes the ring, and
//   finally reports completion.
//
//   Sequence: IDLE -> OPEN -> PUMP -> CLOSE -> [FLUSH] -> DONE -> IDLE
//
// Optional feature:
//   CHIP_FLUSH_EN  when defined, a FLUSH state follows a normal (non-aborted)
//                  CLOSE and drives ctrl_flush[ring] for FLUSH_CYCLES clocks.
//                  When undefined, ctrl_flush is tied to 0.
//
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active-high
//   cmd_valid      command request
//   cmd_ready      high only in IDLE; a command is accepted on cmd_valid & cmd_ready
//   cmd_ring       target ring index
//   cmd_inlet      source inlet index
//   cmd_strokes    number of pump strokes to run (0 skips pumping)
//   cmd_reverse    run the pump pattern backwards
//   abort          terminate the current command (honoured in OPEN/PUMP only)
//   ctrl_inlet     inlet valve open, one-hot or 0
//   ctrl_ring_in   ring inlet valve open, one-hot or 0
//   ctrl_ring_out  ring outlet valve open, one-hot or 0
//   ctrl_pump      pump chambers pressurised (1 = closed)
//   ctrl_flush     ring flush valve open, one-hot or 0
//   busy           command in progress
//   done           1-cycle pulse: command completed or aborted
//   err            1-cycle pulse: command rejected (index out of range)
//   aborted        1-cycle pulse, coincident with done when the command was aborted
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module chip_valve_sequencer #(
    parameter int NUM_RINGS    = 6,
    parameter int NUM_INLETS   = 5,
    parameter int STROKE_W     = 8,
    parameter int PUMP_DIV     = 4,
    parameter int SETTLE       = 8,
    parameter int FLUSH_CYCLES = 16,
    localparam int RING_W      = (NUM_RINGS  > 1) ? $clog2(NUM_RINGS)  : 1,
    localparam int INLET_W     = (NUM_INLETS > 1) ? $clog2(NUM_INLETS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [RING_W-1:0]     cmd_ring,
    input  logic [INLET_W-1:0]    cmd_inlet,
    input  logic [STROKE_W-1:0]   cmd_strokes,
    input  logic                  cmd_reverse,
    input  logic                  abort,
    output logic [NUM_INLETS-1:0] ctrl_inlet,
    output logic [NUM_RINGS-1:0]  ctrl_ring_in,
    output logic [NUM_RINGS-1:0]  ctrl_ring_out,
    output logic [2:0]            ctrl_pump,
    output logic [NUM_RINGS-1:0]  ctrl_flush,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  aborted
);

    // One shared interval counter serves the settle, pump-phase and flush timers,
    // so it is sized for the longest of the three.
    localparam int MAX_A   = (SETTLE > PUMP_DIV) ? SETTLE : PUMP_DIV;
    localparam int MAX_CNT = (MAX_A > FLUSH_CYCLES) ? MAX_A : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_PUMP,
        S_CLOSE,
        S_FLUSH,
        S_DONE
    } state_t;

    // Pump chamber pattern P0..P5 of one peristaltic stroke.
    function automatic logic [2:0] pump_pattern(input logic [2:0] phase);
        logic [2:0] pat;
        case (phase)
            3'd0:    pat = 3'b011;
            3'd1:    pat = 3'b001;
            3'd2:    pat = 3'b101;
            3'd3:    pat = 3'b100;
            3'd4:    pat = 3'b110;
            3'd5:    pat = 3'b010;
            default: pat = 3'b000;
        endcase
        return pat;
    endfunction

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            step_q, step_d;
    logic [STROKE_W-1:0]   strokes_q, strokes_d;
    logic [RING_W-1:0]     ring_q, ring_d;
    logic [INLET_W-1:0]    inlet_q, inlet_d;
    logic                  reverse_q, reverse_d;
    logic                  abort_flag_q, abort_flag_d;

    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  aborted_q, aborted_d;
    logic [NUM_INLETS-1:0] inlet_v_q, inlet_v_d;
    logic [NUM_RINGS-1:0]  ring_in_q, ring_in_d;
    logic [NUM_RINGS-1:0]  ring_out_q, ring_out_d;
    logic [2:0]            pump_q, pump_d;
    logic [NUM_RINGS-1:0]  flush_q, flush_d;

    logic                  cmd_bad;
    logic [2:0]            phase_d;

    assign cmd_bad = (32'(cmd_ring) >= 32'(NUM_RINGS)) || (32'(cmd_inlet) >= 32'(NUM_INLETS));

    // Next-state logic.
    // NOTE: every signal driven here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        step_d       = step_q;
        strokes_d    = strokes_q;
        ring_d       = ring_q;
        inlet_d      = inlet_q;
        reverse_d    = reverse_q;
        abort_flag_d = abort_flag_q;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // cmd_ready is high throughout IDLE, so cmd_valid alone means accept.
                // abort is deliberately not looked at here.
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        ring_d       = cmd_ring;
                        inlet_d      = cmd_inlet;
                        strokes_d    = cmd_strokes;
                        reverse_d    = cmd_reverse;
                        abort_flag_d = 1'b0;
                        step_d       = '0;
                        state_d      = S_OPEN;
                    end
                end
            end

            S_OPEN: begin
                if (abort) begin
                    abort_flag_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_CLOSE;
                end else if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    step_d  = '0;
                    state_d = (strokes_q == '0) ? S_CLOSE : S_PUMP;
                end
            end

            S_PUMP: begin
                if (abort) begin
                    abort_flag_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_CLOSE;
                end else if (cnt_q == CNT_W'(PUMP_DIV - 1)) begin
                    cnt_d = '0;
                    if (step_q == 3'd5) begin
                        // Stroke finished: count it down; the last one leaves PUMP.
                        step_d    = '0;
                        strokes_d = strokes_q - 1'b1;
                        if (strokes_q == STROKE_W'(1)) begin
                            state_d = S_CLOSE;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end

            S_CLOSE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
`ifdef CHIP_FLUSH_EN
                    if (!abort_flag_q) begin
                        state_d = S_FLUSH;
                    end
`endif
                end
            end

            S_FLUSH: begin
                if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and captured in flops, so the pads
    // change on the same edge as the state they belong to.
    always_comb begin
        ready_d    = (state_d == S_IDLE);
        busy_d     = (state_d == S_OPEN) || (state_d == S_PUMP) ||
                     (state_d == S_CLOSE) || (state_d == S_FLUSH);
        done_d     = (state_d == S_DONE);
        aborted_d  = (state_d == S_DONE) && abort_flag_d;
        inlet_v_d  = '0;
        ring_in_d  = '0;
        ring_out_d = '0;
        pump_d     = '0;
        flush_d    = '0;
        // Reverse walks P0,P5,P4,..,P1: phase = (6 - step) mod 6.
        phase_d    = (reverse_d && (step_d != '0)) ? (3'd6 - step_d) : step_d;

        if ((state_d == S_OPEN) || (state_d == S_PUMP)) begin
            inlet_v_d  = NUM_INLETS'(1) << inlet_d;
            ring_in_d  = NUM_RINGS'(1) << ring_d;
            ring_out_d = NUM_RINGS'(1) << ring_d;
        end
        if (state_d == S_PUMP) begin
            pump_d = pump_pattern(phase_d);
        end
`ifdef CHIP_FLUSH_EN
        if (state_d == S_FLUSH) begin
            flush_d = NUM_RINGS'(1) << ring_d;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            step_q       <= '0;
            strokes_q    <= '0;
            ring_q       <= '0;
            inlet_q      <= '0;
            reverse_q    <= 1'b0;
            abort_flag_q <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            aborted_q    <= 1'b0;
            inlet_v_q    <= '0;
            ring_in_q    <= '0;
            ring_out_q   <= '0;
            pump_q       <= '0;
            flush_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            strokes_q    <= strokes_d;
            ring_q       <= ring_d;
            inlet_q      <= inlet_d;
            reverse_q    <= reverse_d;
            abort_flag_q <= abort_flag_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            aborted_q    <= aborted_d;
            inlet_v_q    <= inlet_v_d;
            ring_in_q    <= ring_in_d;
            ring_out_q   <= ring_out_d;
            pump_q       <= pump_d;
            flush_q      <= flush_d;
        end
    end

    assign cmd_ready     = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign aborted       = aborted_q;
    assign ctrl_inlet    = inlet_v_q;
    assign ctrl_ring_in  = ring_in_q;
    assign ctrl_ring_out = ring_out_q;
    assign ctrl_pump     = pump_q;
    assign ctrl_flush    = flush_q;

endmodule
